// File: rtl/rvl_arb_pkg.sv
// Shared types and helpers for the Reveal user-register port arbiter.
// RVL_ARB_FIXED_PRIO_EN selects fixed priority in rvl_rr_arbiter.
package rvl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam int LAT_W = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rvl_rr_arbiter.sv
// Combinational requester arbiter: round-robin after rr_ptr, or lowest index
// when RVL_ARB_FIXED_PRIO_EN is defined (rr_ptr then ignored).
module rvl_rr_arbiter
  import rvl_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] idx_chain [NUM_REQ+1];

`ifdef RVL_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;
  assign grant      = req & (~req + NUM_REQ'(1));
`else
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (ID_W'(gi) > rr_ptr);
  end

  // Requests above the pointer take precedence; otherwise wrap to the lowest set bit.
  assign upper_req = req & upper_mask;
  assign grant = (|upper_req) ? (upper_req & (~upper_req + NUM_REQ'(1)))
                              : (req & (~req + NUM_REQ'(1)));
`endif

  assign idx_chain[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc
    assign idx_chain[gi+1] = idx_chain[gi] | (grant[gi] ? ID_W'(gi) : '0);
  end
  assign grant_idx = idx_chain[NUM_REQ];

endmodule

// File: rtl/rvl_reg_intf_arbiter.sv
// Shares the Reveal Controller user register port between NUM_REQ requesters,
// one transaction at a time. RVL_ARB_FIXED_PRIO_EN selects fixed priority.
module rvl_reg_intf_arbiter
  import rvl_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                             sys_clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             usr_ce,
  output logic                             usr_we,
  output logic [ADDR_WIDTH-1:0]            usr_addr,
  output logic [DATA_WIDTH-1:0]            usr_wdata,
  input  logic [DATA_WIDTH-1:0]            usr_rdata,
  output logic                             busy
);

  localparam int ID_W = clog2(NUM_REQ);

  state_t              state_reg;
  logic [ID_W-1:0]     owner_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  owner_onehot;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rvl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef RVL_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_reg;

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)
      rr_ptr_reg <= ID_W'(NUM_REQ - 1);
    else if (state_reg == IDLE && |req_valid)
      rr_ptr_reg <= grant_idx;
  end
  assign rr_ptr = rr_ptr_reg;
`endif

  // Ready is combinational; gating with rstn keeps it low while reset is held.
  assign req_ready    = (state_reg == IDLE && rstn) ? grant : '0;
  assign busy         = (state_reg != IDLE);
  assign owner_onehot = NUM_REQ'(1) << owner_reg;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      lat_cnt_reg <= '0;
      usr_ce      <= 1'b0;
      usr_we      <= 1'b0;
      usr_addr    <= '0;
      usr_wdata   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            owner_reg <= grant_idx;
            usr_ce    <= 1'b1;
            usr_we    <= req_we[grant_idx];
            usr_addr  <= addr_arr[grant_idx];
            usr_wdata <= wdata_arr[grant_idx];
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          // usr_addr is left alone so the register port sees a stable address.
          usr_ce    <= 1'b0;
          usr_we    <= 1'b0;
          usr_wdata <= '0;
          if (usr_we) begin
            rsp_valid <= owner_onehot;
            rsp_rdata <= '0;
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= LAT_W'(RD_LATENCY - 1);
            state_reg   <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (lat_cnt_reg == '0) begin
            rsp_rdata <= usr_rdata;
            rsp_valid <= owner_onehot;
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvl_reg_intf_arbiter.sv
// Scoreboard bench for rvl_reg_intf_arbiter (RD_LATENCY=1) plus a latency-4 instance.
// Honours RVL_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_rvl_reg_intf_arbiter;

  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int RDL = 1;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rstn;
  logic preload;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Main DUT signals
  logic          v_valid [N];
  logic          v_we    [N];
  logic [AW-1:0] v_addr  [N];
  logic [DW-1:0] v_wdata [N];
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, usr_wdata, usr_rdata;
  logic [AW-1:0]   usr_addr;
  logic            usr_ce, usr_we, busy;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_valid[gi]             = v_valid[gi];
    assign req_we[gi]                = v_we[gi];
    assign req_addr[gi*AW +: AW]     = v_addr[gi];
    assign req_wdata[gi*DW +: DW]    = v_wdata[gi];
  end

  rvl_reg_intf_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .usr_ce(usr_ce), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_rdata(usr_rdata), .busy(busy)
  );

  // Register-file stand-in with RDL-cycle read latency
  logic [DW-1:0] regs    [16];
  logic [DW-1:0] rd_pipe [RDL];
  always @(posedge sys_clk) begin
    if (preload) begin
      for (int k = 0; k < 16; k++) regs[k] <= DW'(16'h1000 + k);
      regs[5] <= 16'h1234;
    end else if (usr_ce && usr_we) begin
      regs[usr_addr[3:0]] <= usr_wdata;
    end
    rd_pipe[0] <= (usr_ce && !usr_we) ? regs[usr_addr[3:0]] : 16'hDEAD;
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign usr_rdata = rd_pipe[RDL-1];

  // Latency-4 instance
  logic [N-1:0]    req_valid4, req_ready4, req_we4, rsp_valid4;
  logic [N*AW-1:0] req_addr4;
  logic [N*DW-1:0] req_wdata4;
  logic [DW-1:0]   rsp_rdata4, usr_wdata4, usr_rdata4;
  logic [AW-1:0]   usr_addr4;
  logic            usr_ce4, usr_we4, busy4;
  logic [DW-1:0]   pipe4 [4];

  rvl_reg_intf_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4)) dut4 (
    .sys_clk(sys_clk), .rstn(rstn),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
    .req_addr(req_addr4), .req_wdata(req_wdata4),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
    .usr_ce(usr_ce4), .usr_we(usr_we4), .usr_addr(usr_addr4),
    .usr_wdata(usr_wdata4), .usr_rdata(usr_rdata4), .busy(busy4)
  );

  always @(posedge sys_clk) begin
    pipe4[0] <= usr_ce4 ? (usr_addr4 ^ 16'hA5A5) : 16'h0000;
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign usr_rdata4 = pipe4[3];

  // Scoreboard
  typedef struct { int id; logic rd; logic [DW-1:0] data; int due; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int due; } iss_t;
  rsp_t rsp_q [$];
  iss_t iss_q [$];
  int   grant_id  [$];
  int   grant_cyc [$];
  logic [DW-1:0] exp_mem [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    rsp_t r;
    iss_t s;
    bit   ok;
    ok = 0;
    @(negedge sys_clk);
    v_valid[i] = 1'b1; v_we[i] = we; v_addr[i] = addr; v_wdata[i] = wdata;
    #1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (req_ready[i]) ok = 1;
      else begin @(negedge sys_clk); #1; end
    end
    chk($sformatf("ready_seen_req%0d", i), 64'(ok), 64'd1);
    if (!ok) begin
      v_valid[i] = 1'b0;
      return;
    end
    grant_id.push_back(i);
    grant_cyc.push_back(cyc);
    s = '{we, addr, wdata, cyc + 1};
    iss_q.push_back(s);
    r.id = i; r.rd = !we; r.data = we ? '0 : exp_mem[addr[3:0]];
    r.due = cyc + 2 + (we ? 0 : RDL);
    rsp_q.push_back(r);
    if (we) exp_mem[addr[3:0]] = wdata;
    @(posedge sys_clk); #1;
    v_valid[i] = 1'b0;
  endtask

  // Monitor: responses, issue cycles and idle-bus invariants
  logic [AW-1:0] prev_addr;
  logic          prev_ce;
  always @(negedge sys_clk) begin
    if (!rstn) begin
      prev_addr <= usr_addr;
      prev_ce   <= 1'b0;
    end else begin
      if (rsp_valid != '0) begin
        chk("rsp_pending", 64'(rsp_q.size() > 0), 64'd1);
        if (rsp_q.size() > 0) begin
          rsp_t r;
          r = rsp_q.pop_front();
          $display("rsp req%0d rd=%0b rdata=0x%04h cycle=%0d", r.id, r.rd, rsp_rdata, cyc);
          chk("rsp_valid_owner", 64'(rsp_valid), 64'd1 << r.id);
          chk("rsp_cycle", 64'(cyc), 64'(r.due));
          if (r.rd) chk("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
        end
      end
      if (usr_ce) begin
        chk("ce_one_cycle", 64'(prev_ce), 64'd0);
        chk("iss_pending", 64'(iss_q.size() > 0), 64'd1);
        if (iss_q.size() > 0) begin
          iss_t s;
          s = iss_q.pop_front();
          chk("iss_we", 64'(usr_we), 64'(s.we));
          chk("iss_addr", 64'(usr_addr), 64'(s.addr));
          chk("iss_wdata", 64'(usr_wdata), 64'(s.wdata));
          chk("iss_cycle", 64'(cyc), 64'(s.due));
        end
      end else begin
        chk("idle_addr_hold", 64'(usr_addr), 64'(prev_addr));
        chk("idle_we_wdata", 64'({usr_we, usr_wdata}), 64'd0);
      end
      prev_addr <= usr_addr;
      prev_ce   <= usr_ce;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gstart;
    int exp_seq [6];
    int g4;

    for (int i = 0; i < N; i++) begin
      v_valid[i] = 1'b0; v_we[i] = 1'b0; v_addr[i] = '0; v_wdata[i] = '0;
    end
    for (int k = 0; k < 16; k++) exp_mem[k] = DW'(16'h1000 + k);
    exp_mem[5] = 16'h1234;
    req_valid4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0;
    rstn = 1'b0; preload = 1'b1;

    repeat (3) @(negedge sys_clk);
    #1;
    chk("reset_outputs", 64'({rsp_valid, usr_ce, usr_we, usr_addr, usr_wdata, rsp_rdata, busy, req_ready}), 64'd0);
    chk("reset_outputs_l4", 64'({rsp_valid4, usr_ce4, busy4, usr_addr4}), 64'd0);
    #1;
    rstn = 1'b1; preload = 1'b0;

    // Write, read-back, then read preloaded register from requester 1
    do_req(0, 1'b1, 16'h0003, 16'hBEEF);
    do_req(0, 1'b0, 16'h0003, 16'h0000);
    do_req(1, 1'b0, 16'h0005, 16'h0000);
    repeat (5) @(negedge sys_clk);

    // Contention: requester 0 wants 6 transactions, requester 1 wants 3
    gstart = grant_id.size();
    fork
      begin
        for (int k = 0; k < 6; k++) do_req(0, (k % 2 == 0), AW'(8 + k), DW'(16'h1100 + k));
      end
      begin
        for (int k = 0; k < 3; k++) do_req(1, 1'b0, AW'(16'h000A + k), 16'h0000);
      end
    join
`ifdef RVL_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
    for (int k = 0; k < 6; k++) chk($sformatf("grant_order_%0d", k), 64'(grant_id[gstart + k]), 64'(exp_seq[k]));
    for (int n = 0; n < 20 && rsp_q.size() > 0; n++) @(negedge sys_clk);
    chk("drain_contention", 64'(rsp_q.size()), 64'd0);

    // Reset asserted while the read sits in WAIT_RD
    do_req(0, 1'b0, 16'h0004, 16'h0000);
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("busy_in_wait_rd", 64'(busy), 64'd1);
    #1;
    rstn = 1'b0;
    v_valid[0] = 1'b1; v_valid[1] = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({rsp_valid, usr_ce, usr_addr, busy, req_ready}), 64'd0);
    rsp_q.delete();
    v_valid[0] = 1'b0; v_valid[1] = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #2;
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    gstart = grant_id.size();
    fork
      do_req(0, 1'b1, 16'h0001, 16'h5A5A);
      do_req(1, 1'b1, 16'h0002, 16'hA5A5);
    join
    chk("grant_after_reset", 64'(grant_id[gstart]), 64'd0);
    repeat (4) @(negedge sys_clk);

    // Back-to-back writes from requester 1
    gstart = grant_id.size();
    for (int k = 0; k < 3; k++) do_req(1, 1'b1, AW'(16'h000C + k), DW'(16'h7700 + k));
    for (int k = 1; k < 3; k++)
      chk($sformatf("b2b_ready_spacing_%0d", k), 64'(grant_cyc[gstart + k] - grant_cyc[gstart + k - 1]), 64'd2);
    for (int n = 0; n < 20 && rsp_q.size() > 0; n++) @(negedge sys_clk);
    chk("drain_b2b", 64'(rsp_q.size()), 64'd0);

    // RD_LATENCY=4 instance: ready -> rsp_valid in 6 cycles, busy for 5
    @(negedge sys_clk);
    req_valid4 = 2'b01; req_we4 = 2'b00; req_addr4 = {16'h0000, 16'h0007};
    #1;
    chk("l4_ready", 64'(req_ready4), 64'd1);
    chk("l4_busy_at_grant", 64'(busy4), 64'd0);
    g4 = cyc;
    @(posedge sys_clk); #1;
    req_valid4 = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      @(negedge sys_clk);
      chk($sformatf("l4_busy_c%0d", k), 64'(busy4), 64'(k <= 5));
      chk($sformatf("l4_ce_c%0d", k), 64'(usr_ce4), 64'(k == 1));
      chk($sformatf("l4_rsp_c%0d", k), 64'(rsp_valid4), (k == 6) ? 64'd1 : 64'd0);
      if (k == 6) begin
        $display("rsp l4 req0 rdata=0x%04h cycle=%0d (grant %0d)", rsp_rdata4, cyc, g4);
        chk("l4_rdata", 64'(rsp_rdata4), 64'h0000_0000_0000_A5A2);
      end
    end

    repeat (3) @(negedge sys_clk);
    chk("final_rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("final_iss_queue_empty", 64'(iss_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
